parallel_to_serial_bit_feeder_fsm: RTL and testbench



---
 rtl/parallel_to_serial_bit_feeder_fsm_pkg.sv | 13 +
 rtl/parallel_to_serial_bit_feeder_fsm.sv | 114 +++++++++++
 tb/tb_parallel_to_serial_bit_feeder_fsm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_bit_feeder_fsm_pkg.sv
// Shared state encoding and default sizing for the parallel-to-serial bit feeder.
package parallel_to_serial_bit_feeder_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_GAP_CYCLES = 0;

endpackage

// File: rtl/parallel_to_serial_bit_feeder_fsm.sv
// Serialises WIDTH-bit words MSB first; first bit on a one cycle after accept, optional idle gap per word.
// bit_en=0 freezes shifting and the gap count; in_ready rises in IDLE or on the last bit when words can chain.
module parallel_to_serial_bit_feeder_fsm
   import parallel_to_serial_bit_feeder_fsm_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             bit_en,
   output logic             a,
   output logic             a_valid,
   output logic             a_last,
   output logic             busy
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
   localparam bit            HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [3:0]    GAP_TOP = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_gap;
   logic             r_a;
   logic             r_a_valid;
   logic             r_a_last;
   logic             r_busy;

   logic             w_lsb;
   logic             w_accept;

   assign w_lsb    = (r_state == ST_SHIFT) && (r_cnt == '0);
   assign in_ready = (r_state == ST_IDLE) || (w_lsb && bit_en && !HAS_GAP);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_gap     <= '0;
         r_a       <= 1'b0;
         r_a_valid <= 1'b0;
         r_a_last  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // a_valid marks a freshly presented bit, so it defaults low on every edge
         r_a_valid <= 1'b0;
         r_a_last  <= 1'b0;
         if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_sr      <= in_data;
            r_cnt     <= CNT_TOP;
            r_a       <= in_data[WIDTH-1];
            r_a_valid <= 1'b1;
            r_busy    <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_a    <= 1'b0;
                  r_busy <= 1'b0;
               end
               ST_SHIFT: begin
                  if (bit_en) begin
                     r_sr <= r_sr << 1;
                     if (r_cnt != '0) begin
                        r_cnt     <= r_cnt - CW'(1);
                        r_a       <= r_sr[WIDTH-2];
                        r_a_valid <= 1'b1;
                        r_a_last  <= (r_cnt == CW'(1));
                     end else if (HAS_GAP) begin
                        r_state <= ST_GAP;
                        r_gap   <= GAP_TOP;
                        r_a     <= 1'b0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_a     <= 1'b0;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               ST_GAP: begin
                  r_a <= 1'b0;
                  if (bit_en) begin
                     if (r_gap == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_gap <= r_gap - 4'd1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_a     <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign a       = r_a;
   assign a_valid = r_a_valid;
   assign a_last  = r_a_last;
   assign busy    = r_busy;

endmodule

// File: tb/tb_parallel_to_serial_bit_feeder_fsm.sv
// Directed bench: two feeder instances (no gap, 3-bit-time gap) plus a 110011 detector on the no-gap stream.
module tb_parallel_to_serial_bit_feeder_fsm;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       bit_en;

   logic rdy0, a0, av0, al0, busy0;
   logic rdy3, a3, av3, al3, busy3;

   logic [5:0] hist;
   logic       det;

   int n_chk  = 0;
   int n_pass = 0;

   parallel_to_serial_bit_feeder_fsm #(.WIDTH(8), .GAP_CYCLES(0)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (rdy0),
      .bit_en   (bit_en),
      .a        (a0),
      .a_valid  (av0),
      .a_last   (al0),
      .busy     (busy0)
   );

   parallel_to_serial_bit_feeder_fsm #(.WIDTH(8), .GAP_CYCLES(3)) u_dut3 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (rdy3),
      .bit_en   (bit_en),
      .a        (a3),
      .a_valid  (av3),
      .a_last   (al3),
      .busy     (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 110011 sequence detector; pulse appears the cycle after the matching bit
   always_ff @(posedge clk) begin
      if (!rst) begin
         hist <= '0;
         det  <= 1'b0;
      end else if (av0) begin
         hist <= {hist[4:0], a0};
         det  <= ({hist[4:0], a0} == 6'b110011);
      end else begin
         det <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      in_valid = 1'b0;
      bit_en   = 1'b1;
      tick();
      tick();
      rst = 1'b1;
   endtask

   logic [7:0]  w8;
   logic [15:0] w16;

   initial begin
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      bit_en   = 1'b1;
      tick();
      tick();
      chk("rst_outs0", {a0, av0, al0, busy0, rdy0}, 5'b00001);
      chk("rst_outs3", {a3, av3, al3, busy3, rdy3}, 5'b00001);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      chk("rst_no_accept", {busy0, av0}, 2'b00);

      // single 0xCC word, no gap, with detector
      do_reset();
      w8       = 8'hCC;
      in_valid = 1'b1;
      in_data  = w8;
      #1;
      chk("cc_rdy_idle", rdy0, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("cc_bit", {av0, al0, a0}, {1'b1, (i == 7), w8[7-i]});
         chk("cc_det", det, (i == 6));
         tick();
      end
      chk("cc_idle", {busy0, av0, al0, a0, rdy0}, 5'b00001);
      chk("cc_det_end", det, 1'b0);

      // back-to-back 0xA5 then 0x3C
      do_reset();
      w16      = 16'hA53C;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_data  = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_bit", {av0, al0, a0}, {1'b1, (i == 7 || i == 15), w16[15-i]});
         in_valid = (i < 8);
         #1;
         if (i == 6) chk("b2b_rdy_mid", rdy0, 1'b0);
         if (i == 7) chk("b2b_rdy_lsb", rdy0, 1'b1);
         tick();
      end
      chk("b2b_idle", {busy0, av0}, 2'b00);

      // gap of 3 bit-times after 0xFF
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("gap_bit", {av3, al3, a3}, {1'b1, (i == 7), 1'b1});
         if (i == 7) chk("gap_rdy_lsb", rdy3, 1'b0);
         tick();
      end
      for (int j = 0; j < 3; j++) begin
         chk("gap_hold", {av3, a3, rdy3, busy3}, 4'b0001);
         tick();
      end
      chk("gap_done", {rdy3, busy3, av3}, 3'b100);

      // bit_en stall after the third bit of 0xCC
      do_reset();
      w8       = 8'hCC;
      in_valid = 1'b1;
      in_data  = w8;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_pre", {av0, a0}, {1'b1, w8[7-i]});
         if (i == 2) bit_en = 1'b0;
         tick();
      end
      for (int s = 0; s < 4; s++) begin
         chk("stall_hold", {av0, a0, busy0, rdy0}, 4'b0010);
         if (s == 3) bit_en = 1'b1;
         tick();
      end
      for (int i = 3; i < 8; i++) begin
         chk("stall_post", {av0, al0, a0}, {1'b1, (i == 7), w8[7-i]});
         tick();
      end
      chk("stall_idle", {busy0, av0}, 2'b00);

      // reset on the fifth bit of 0xF0, then 0x81
      do_reset();
      w8       = 8'hF0;
      in_valid = 1'b1;
      in_data  = w8;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("abort_pre", {av0, a0}, {1'b1, w8[7-i]});
         if (i == 4) rst = 1'b0;
         tick();
      end
      chk("abort_rst", {av0, busy0, rdy0, a0}, 4'b0010);
      rst = 1'b1;
      tick();
      chk("abort_quiet", {av0, busy0, a0}, 3'b000);
      w8       = 8'h81;
      in_valid = 1'b1;
      in_data  = w8;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("post_abort_bit", {av0, al0, a0}, {1'b1, (i == 7), w8[7-i]});
         tick();
      end
      chk("post_abort_idle", {busy0, av0, rdy0}, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
